// File: rtl/pcm_pkg.sv
// Shared widths, stereo frame layout and fetch-state encoding for the PCM line reader.
package pcm_pkg;

  localparam int PCM_ADDR_W   = 22;
  localparam int PCM_LINE_W   = 128;
  localparam int PCM_SAMPLE_W = 32;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] l;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAITBUF = 2'd2,
    ST_FLUSH   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pcm_line_fifo.sv
// Small synchronous line FIFO with a combinational head so the reader can pick a frame
// from the oldest line in the same cycle that sample_ready arrives.
module pcm_line_fifo
  import pcm_pkg::*;
#(
  parameter int W     = PCM_LINE_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_din,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [W-1:0]               o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pcm_line_reader.sv
// Fetches PCM lines from the SDRAM arbiter into a line FIFO and hands stereo frames to the
// I2S serializer. Define PCM_LINE_READER_LOOP_EN to replay the same region until reset.
module pcm_line_reader
  import pcm_pkg::*;
#(
  parameter int ADDR_W     = PCM_ADDR_W,
  parameter int LINE_W     = PCM_LINE_W,
  parameter int SAMPLE_W   = PCM_SAMPLE_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_lines,
  input  logic                sdram_wait,
  input  logic                sdram_ac,
  input  logic [LINE_W-1:0]   sdram_rddata,
  output logic                sdram_rd,
  output logic [ADDR_W-1:0]   sdram_addr,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  output logic                busy,
  output logic                done
);

  localparam int FPL   = LINE_W / SAMPLE_W;
  localparam int K_W   = (FPL > 1) ? $clog2(FPL) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t        r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_rem;
  logic                r_busy;
  logic                r_done;
  logic [K_W-1:0]      r_k;
  logic [SAMPLE_W-1:0] r_sample_data;
  logic                r_sample_valid;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [LINE_W-1:0]   w_head;
  logic                w_will_full;
  frame_t              w_frame;

  assign sdram_rd     = (r_state == ST_REQ) && !sdram_wait;
  assign sdram_addr   = r_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_data  = r_sample_data;
  assign sample_valid = r_sample_valid;

  assign w_push      = sdram_rd && sdram_ac;
  assign w_pop       = sample_ready && !w_empty && (r_k == K_W'(FPL - 1));
  // Full after this edge, accounting for a pop landing in the same cycle as the push.
  assign w_will_full = (w_count + CNT_W'(1) - CNT_W'(w_pop)) == CNT_W'(FIFO_DEPTH);
  assign w_frame     = w_head[SAMPLE_W*r_k +: SAMPLE_W];

  pcm_line_fifo #(
    .W     (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (sdram_rddata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

`ifdef PCM_LINE_READER_LOOP_EN
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_num;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_base <= '0;
      r_num  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_base <= base_addr;
      r_num  <= num_lines;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (num_lines != '0) begin
              r_addr  <= base_addr;
              r_rem   <= num_lines;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= ST_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (w_push) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rem  <= r_rem - ADDR_W'(1);
            if (r_rem == ADDR_W'(1)) begin
`ifdef PCM_LINE_READER_LOOP_EN
              r_addr <= r_base;
              r_rem  <= r_num;
              if (w_will_full) r_state <= ST_WAITBUF;
`else
              r_state <= ST_FLUSH;
`endif
            end else if (w_will_full) begin
              r_state <= ST_WAITBUF;
            end
          end
        end
        ST_WAITBUF: begin
          if (!w_full) r_state <= ST_REQ;
        end
        ST_FLUSH: begin
          // The head pops together with its last frame, so empty means playback is over.
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_k            <= '0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= sample_ready;
      if (sample_ready) begin
        if (!w_empty) begin
          r_sample_data <= w_frame;
          r_k           <= (r_k == K_W'(FPL - 1)) ? '0 : r_k + K_W'(1);
        end else begin
          r_sample_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_line_reader.sv
// Randomized bench for pcm_line_reader: plays regions against a frame-queue reference model.
// Build with PCM_LINE_READER_LOOP_EN to check the looping variant.
`timescale 1ns/1ps
module tb_pcm_line_reader;

  localparam int ADDR_W     = 22;
  localparam int LINE_W     = 128;
  localparam int SAMPLE_W   = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int FPL        = LINE_W / SAMPLE_W;
  localparam int MAX_CYC    = 4000;
  localparam int NO_STALL   = 1000000;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W-1:0]   num_lines = '0;
  logic                sdram_wait = 1'b0;
  logic                sdram_ac = 1'b0;
  logic [LINE_W-1:0]   sdram_rddata = '0;
  logic                sdram_rd;
  logic [ADDR_W-1:0]   sdram_addr;
  logic                sample_ready = 1'b0;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                busy;
  logic                done;

  pcm_line_reader #(
    .ADDR_W     (ADDR_W),
    .LINE_W     (LINE_W),
    .SAMPLE_W   (SAMPLE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_lines    (num_lines),
    .sdram_wait   (sdram_wait),
    .sdram_ac     (sdram_ac),
    .sdram_rddata (sdram_rddata),
    .sdram_rd     (sdram_rd),
    .sdram_addr   (sdram_addr),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frames still owed to the serializer, oldest first, plus the address walk.
  logic [SAMPLE_W-1:0] frames_q[$];
  logic [ADDR_W-1:0]   exp_addr;
  logic [ADDR_W-1:0]   base_m;
  int                  num_m;
  int                  accepted;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs are already driven; predict the edge, take it, then compare.
  task automatic cycle();
    logic                exp_v;
    logic [SAMPLE_W-1:0] exp_d;
    #1;
    if (sdram_wait) check_val("rd_under_wait", sdram_rd, 1'b0);
    exp_v = sample_ready;
    exp_d = '0;
    if (sample_ready && frames_q.size() > 0) exp_d = frames_q.pop_front();
    if (sdram_rd && sdram_ac) begin
      check_val("rd_addr", sdram_addr, exp_addr);
      accepted++;
      exp_addr = exp_addr + ADDR_W'(1);
`ifdef PCM_LINE_READER_LOOP_EN
      if ((accepted % num_m) == 0) exp_addr = base_m;
`endif
      for (int i = 0; i < FPL; i++) frames_q.push_back(sdram_rddata[SAMPLE_W*i +: SAMPLE_W]);
    end
    @(posedge clk);
    #1;
    check_val("sample_valid", sample_valid, exp_v);
    if (exp_v) check_val("sample_data", sample_data, exp_d);
    check_val("fifo_bound", ((frames_q.size() + FPL - 1) / FPL) <= FIFO_DEPTH, 1'b1);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    start        = 1'b0;
    sample_ready = 1'b0;
    sdram_ac     = 1'b0;
    sdram_wait   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("rst_rd", sdram_rd, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_valid", sample_valid, 1'b0);
    check_val("rst_data", sample_data, '0);
    check_val("rst_addr", sdram_addr, '0);
    reset_n = 1'b1;
    frames_q.delete();
    accepted = 0;
  endtask

  task automatic run_play(input logic [ADDR_W-1:0] base, input int num, input int ready_per,
                          input int ready_hold, input int ac_hold, input int wait_pct,
                          input int stall_at);
    int n;
    int done_wait;
    int exp_acc;
    bit complete;
    do_reset();
    base_m    = base;
    num_m     = num;
    exp_addr  = base;
    base_addr = base;
    num_lines = ADDR_W'(num);
    start     = 1'b1;
    cycle();
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    num_lines = ADDR_W'($urandom);
    check_val("busy_after_start", busy, 1'b1);
    check_val("done_after_start", done, 1'b0);
    n = 0;
    done_wait = 0;
    complete = 1'b0;
    while (n < MAX_CYC) begin
      if (n < ready_hold) sample_ready = 1'b0;
      else if (ready_per == 0) sample_ready = ($urandom_range(0, 3) == 0);
      else sample_ready = ((n % ready_per) == 0);
      sdram_ac     = (n >= ac_hold) && ($urandom_range(0, 99) < 70);
      sdram_wait   = ((n >= stall_at) && (n < stall_at + 20)) || ($urandom_range(0, 99) < wait_pct);
      sdram_rddata = {$urandom, $urandom, $urandom, $urandom};
      start        = !complete && ($urandom_range(0, 15) == 0);
      cycle();
      if (ready_hold > 0 && n == ready_hold - 1) begin
        exp_acc = (num < FIFO_DEPTH) ? num : FIFO_DEPTH;
`ifdef PCM_LINE_READER_LOOP_EN
        exp_acc = FIFO_DEPTH;
`endif
        check_val("backpressure_lines", accepted, exp_acc);
        check_val("backpressure_rd", sdram_rd, 1'b0);
      end
`ifdef PCM_LINE_READER_LOOP_EN
      check_val("loop_busy", busy, 1'b1);
      check_val("loop_done", done, 1'b0);
      if (n >= 300) break;
`else
      complete = (accepted == num) && (frames_q.size() == 0);
      if (!complete) begin
        check_val("busy_playing", busy, 1'b1);
        check_val("done_playing", done, 1'b0);
      end else begin
        done_wait++;
        if (done || done_wait > 4) break;
      end
`endif
      n++;
    end
    start        = 1'b0;
    sample_ready = 1'b0;
    sdram_ac     = 1'b0;
    sdram_wait   = 1'b0;
`ifndef PCM_LINE_READER_LOOP_EN
    check_val("lines_fetched", accepted, num);
    check_val("done_end", done, 1'b1);
    check_val("busy_end", busy, 1'b0);
    cycle();
    check_val("done_held", done, 1'b1);
    check_val("idle_rd", sdram_rd, 1'b0);
`endif
  endtask

  initial begin
    accepted = 0;
    num_m    = 1;
    do_reset();

    // Zero-length playback finishes on the edge after start without touching SDRAM.
    base_addr = 22'h000123;
    num_lines = '0;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    check_val("zero_done", done, 1'b1);
    check_val("zero_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sdram_ac = 1'b1;
      cycle();
      check_val("zero_no_rd", sdram_rd, 1'b0);
      check_val("zero_done_held", done, 1'b1);
    end

    // Reset while a request is outstanding; a late acknowledge must not load a line.
    do_reset();
    base_m    = 22'h000055;
    num_m     = 5;
    exp_addr  = 22'h000055;
    base_addr = 22'h000055;
    num_lines = 22'd5;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check_val("rd_before_reset", sdram_rd, 1'b1);
    reset_n  = 1'b0;
    sdram_ac = 1'b1;
    @(posedge clk);
    #1;
    check_val("midreq_rd", sdram_rd, 1'b0);
    check_val("midreq_busy", busy, 1'b0);
    check_val("midreq_done", done, 1'b0);
    reset_n = 1'b1;
    frames_q.delete();
    sample_ready = 1'b1;
    cycle();
    sample_ready = 1'b0;
    cycle();
    check_val("post_reset_rd", sdram_rd, 1'b0);
    sdram_ac = 1'b0;

    run_play(22'h000100, 3, 8, 0, 0, 0, NO_STALL);      // basic play
    run_play(22'h002000, 4, 8, 0, 0, 0, 2);             // 20-cycle wait stall in REQ
    run_play(22'h000040, 5, 8, 100, 0, 0, NO_STALL);    // consumer backpressure
    run_play(22'h000077, 2, 8, 0, 200, 0, NO_STALL);    // underrun while SDRAM is slow
    run_play(22'h3FFFFF, 2, 0, 0, 0, 20, NO_STALL);     // address wrap
    for (int r = 0; r < 6; r++) begin
      int per;
      case ($urandom_range(0, 3))
        0:       per = 0;
        1:       per = 1;
        2:       per = 3;
        default: per = 8;
      endcase
      run_play(ADDR_W'($urandom), $urandom_range(1, 8), per, 0, 0, $urandom_range(0, 40), NO_STALL);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_line_reader.md
Name: pcm_line_reader

Overview:
- Downstream consumer of the SDRAM arbiter's PCM port.
- Fetches 128-bit PCM lines from SDRAM over the arbiter read handshake and buffers them in a small line FIFO.
- Hands 32-bit stereo frames ({R[15:0],L[15:0]}) to the I2S serializer, one per sample_ready pulse.
- Drives the busy/done status that the arbiter uses to move from PCM to Halted.

Parameters:
- ADDR_W, 22, SDRAM line-address width.
- LINE_W, 128, SDRAM data word width; must be a multiple of SAMPLE_W.
- SAMPLE_W, 32, stereo frame width; frames per line FPL = LINE_W/SAMPLE_W = 4.
- FIFO_DEPTH, 2, line-buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begin playback
- base_addr  in  ADDR_W  first line address, sampled on start
- num_lines  in  ADDR_W  lines to play, sampled on start
- sdram_wait  in  1  arbiter not granting; 1 forbids sdram_rd
- sdram_ac  in  1  arbiter acknowledge; sdram_rddata valid this cycle
- sdram_rddata  in  LINE_W  read data
- sdram_rd  out  1  read request
- sdram_addr  out  ADDR_W  read line address
- sample_ready  in  1  serializer pulse requesting the next frame
- sample_data  out  SAMPLE_W  frame presented to the serializer
- sample_valid  out  1  1-cycle strobe; sample_data valid
- busy  out  1  playback in progress
- done  out  1  level; playback complete, held until next start

Behaviour:
- Reset (reset_n=0 at clk edge) clears all state; rd, sample_valid, busy and done are 0; sdram_addr and sample_data are 0; FIFO is empty.
- Reset mid-fetch drops sdram_rd on the next edge. A later sdram_ac is ignored.
- Fetch FSM has states IDLE, REQ, WAITBUF, FLUSH.
  - IDLE: on start with num_lines != 0, latch addr=base_addr and remaining=num_lines, set busy=1, done=0, go to REQ.
  - IDLE: on start with num_lines == 0, set done=1 on the next edge; busy stays 0.
  - REQ: sdram_rd = ~sdram_wait; sdram_addr = current addr.
    - Accept a line only when sdram_rd && sdram_ac in the same cycle: push rddata, addr+1 (mod 2^ADDR_W), remaining-1.
    - If remaining hits 0, go to FLUSH.
    - Else if the FIFO becomes full, go to WAITBUF; otherwise stay in REQ (back-to-back allowed).
  - sdram_wait rising while a request is pending deasserts rd with no side effect. The same address is reissued when wait falls.
  - WAITBUF: rd=0; return to REQ when the FIFO is not full.
  - FLUSH: rd=0; when the FIFO is empty and the last frame has been emitted, set busy=0, done=1, go to IDLE.
- Playback:
  - A frame index k (0..FPL-1) walks the FIFO head line; frame k = head[SAMPLE_W*k +: SAMPLE_W], LSB frame first.
  - On sample_ready with the FIFO non-empty: next edge drives sample_data = frame k and sample_valid=1 for one cycle, then k++.
  - On k wrap: pop the head.
  - Latency from sample_ready to sample_valid is exactly 1 cycle.
- Underrun: sample_ready while busy and the FIFO is empty gives sample_data=0 with sample_valid=1; k is unchanged.
- Outside busy, sample_ready gives sample_data=0 with sample_valid=1 (silence).
- start while busy is ignored.
- Simultaneous push and pop in one cycle is legal; the FIFO count is unchanged.
- The FIFO never overflows: a push is possible only in REQ, and REQ is entered only when the FIFO is not full.

Optional Feature:
- Macro: PCM_LINE_READER_LOOP_EN.
- Defined: when remaining hits 0, reload addr=base_addr and remaining=num_lines latched at start, and stay in REQ. done is never raised and busy stays 1 until reset.
- Undefined: one-shot behaviour as above.

Decomposition:
- Shared package pcm_pkg holds:
  - ADDR_W, LINE_W, SAMPLE_W constants
  - frame typedef (struct {logic [15:0] r, l;})
  - fetch-state enum
- Sub-module pcm_line_fifo: synchronous FIFO (push, pop, full, empty, head data, FIFO_DEPTH entries); instantiated once.

Test Plan:
- Basic play: start with base=0x000100, num=3, ac one cycle after each rd, sample_ready every 8 cycles, lines 0x…0003_0002_0001_0000 etc.
  - Expect rd addresses 0x100, 0x101, 0x102.
  - Expect 12 frames in order 0x0000, 0x0001, 0x0002, 0x0003, ….
  - Expect done=1 and busy=0 after the 12th frame.
- Wait stall: sdram_wait=1 for 20 cycles during REQ.
  - Expect rd=0 throughout.
  - Expect the same address reissued afterwards and no lost or duplicated line.
- Backpressure: no sample_ready for 100 cycles.
  - Expect exactly FIFO_DEPTH=2 lines fetched, then WAITBUF with rd=0.
  - Expect fetch to resume after 4 frames are consumed.
- Underrun: ac delayed 200 cycles with sample_ready every 8 cycles.
  - Expect sample_valid with sample_data=0.
  - Expect the first real frame 0x0000 once data arrives.
- Edge cases:
  - num_lines=0 gives done=1 one cycle after start, with no rd.
  - base=0x3FFFFF, num=2 gives addresses 0x3FFFFF then 0x000000.
  - reset_n=0 mid-REQ gives rd=0, busy=0, done=0 on the next edge.
- Loop (PCM_LINE_READER_LOOP_EN): with num=2, expect addresses base, base+1, base, base+1, …; done stays 0.
